// File: rtl/stream_accumulator.sv
// Multi-channel signed stream accumulator: one running sum per channel, one
// result beat (sum, beat count, sticky overflow) per frame closed by s_tlast.
module stream_accumulator #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ACC_W  = 48,
  parameter int unsigned NCH    = 4,
  parameter int unsigned CH_W   = (NCH > 1) ? $clog2(NCH) : 1,
  parameter int unsigned CNT_W  = 16,
  parameter bit          SAT    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic [CH_W-1:0]   s_tid,
  input  logic              s_tlast,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [ACC_W-1:0]  m_tdata,
  output logic [CH_W-1:0]   m_tid,
  output logic [CNT_W-1:0]  m_tcount,
  output logic              m_tovf,
  output logic              m_tlast
);

  localparam int unsigned SUM_W = ACC_W + 1;
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W-1:0] acc_q [NCH];
  logic [CNT_W-1:0] cnt_q [NCH];
  logic             ovf_q [NCH];

  logic             m_tvalid_q;
  logic [ACC_W-1:0] m_tdata_q;
  logic [CH_W-1:0]  m_tid_q;
  logic [CNT_W-1:0] m_tcount_q;
  logic             m_tovf_q;
  logic             m_tlast_q;

  logic             beat_c;
  logic             ch_ok_c;
  logic [CH_W-1:0]  ch_idx_c;
  logic [ACC_W-1:0] acc_sel_c;
  logic [CNT_W-1:0] cnt_sel_c;
  logic [SUM_W-1:0] sum_c;
  logic             ovf_beat_c;
  logic [ACC_W-1:0] acc_d;
  logic [CNT_W-1:0] cnt_d;
  logic             ovf_d;

  // Ready depends only on the output register and downstream, never on s_*.
  assign s_tready = rst & (~m_tvalid_q | m_tready);

  // Per-beat sum, overflow detection, clamp/wrap and saturating count.
  always_comb begin
    beat_c     = s_tvalid & s_tready;
    ch_ok_c    = (32'(s_tid) < NCH);
    ch_idx_c   = ch_ok_c ? s_tid : '0;
    acc_sel_c  = acc_q[ch_idx_c];
    cnt_sel_c  = cnt_q[ch_idx_c];
    sum_c      = {acc_sel_c[ACC_W-1], acc_sel_c}
               + {{(SUM_W-DATA_W){s_tdata[DATA_W-1]}}, s_tdata};
    ovf_beat_c = sum_c[ACC_W] ^ sum_c[ACC_W-1];
    acc_d      = sum_c[ACC_W-1:0];
    if (ovf_beat_c && SAT) begin
      acc_d = sum_c[ACC_W] ? ACC_MIN : ACC_MAX;
    end
    cnt_d = (&cnt_sel_c) ? cnt_sel_c : cnt_sel_c + CNT_W'(1);
    ovf_d = ovf_q[ch_idx_c] | ovf_beat_c;
  end

  // Channel state and the single result register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        acc_q[i] <= '0;
        cnt_q[i] <= '0;
        ovf_q[i] <= 1'b0;
      end
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tid_q    <= '0;
      m_tcount_q <= '0;
      m_tovf_q   <= 1'b0;
      m_tlast_q  <= 1'b0;
    end else begin
      if (m_tvalid_q && m_tready) begin
        m_tvalid_q <= 1'b0;
      end
      if (beat_c && ch_ok_c) begin
        if (s_tlast) begin
          acc_q[ch_idx_c] <= '0;
          cnt_q[ch_idx_c] <= '0;
          ovf_q[ch_idx_c] <= 1'b0;
          m_tvalid_q      <= 1'b1;
          m_tdata_q       <= acc_d;
          m_tid_q         <= ch_idx_c;
          m_tcount_q      <= cnt_d;
          m_tovf_q        <= ovf_d;
          m_tlast_q       <= (ch_idx_c == CH_W'(NCH - 1));
        end else begin
          acc_q[ch_idx_c] <= acc_d;
          cnt_q[ch_idx_c] <= cnt_d;
          ovf_q[ch_idx_c] <= ovf_d;
        end
      end
    end
  end

  assign m_tvalid = m_tvalid_q;
  assign m_tdata  = m_tdata_q;
  assign m_tid    = m_tid_q;
  assign m_tcount = m_tcount_q;
  assign m_tovf   = m_tovf_q;
  assign m_tlast  = m_tlast_q;

endmodule

// File: tb/tb_stream_accumulator.sv
// Bench: default-size accumulator plus two 8-bit/3-channel instances (saturating
// and wrapping) checked against an integer-arithmetic model of frame sums.
module tb_stream_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Default-parameter instance
  logic        a_rst = 1'b0, a_sv = 1'b0, a_last = 1'b0, a_mr = 1'b0;
  logic [31:0] a_data = '0;
  logic [1:0]  a_tid = '0;
  logic        a_sr, a_mv, a_movf, a_mlast;
  logic [47:0] a_md;
  logic [1:0]  a_mid;
  logic [15:0] a_mc;

  stream_accumulator u_a (
    .clk(clk), .rst(a_rst), .s_tvalid(a_sv), .s_tready(a_sr), .s_tdata(a_data),
    .s_tid(a_tid), .s_tlast(a_last), .m_tvalid(a_mv), .m_tready(a_mr),
    .m_tdata(a_md), .m_tid(a_mid), .m_tcount(a_mc), .m_tovf(a_movf), .m_tlast(a_mlast)
  );

  // Small instances sharing one input stream
  logic       b_rst = 1'b0, b_sv = 1'b0, b_last = 1'b0, b_mr = 1'b0;
  logic [7:0] b_data = '0;
  logic [1:0] b_tid = '0;
  logic       bs_sr, bs_mv, bs_movf, bs_mlast, bw_sr, bw_mv, bw_movf, bw_mlast;
  logic [7:0] bs_md, bw_md;
  logic [1:0] bs_mid, bw_mid, bs_mc, bw_mc;

  stream_accumulator #(.DATA_W(8), .ACC_W(8), .NCH(3), .CNT_W(2), .SAT(1'b1)) u_bs (
    .clk(clk), .rst(b_rst), .s_tvalid(b_sv), .s_tready(bs_sr), .s_tdata(b_data),
    .s_tid(b_tid), .s_tlast(b_last), .m_tvalid(bs_mv), .m_tready(b_mr),
    .m_tdata(bs_md), .m_tid(bs_mid), .m_tcount(bs_mc), .m_tovf(bs_movf), .m_tlast(bs_mlast)
  );

  stream_accumulator #(.DATA_W(8), .ACC_W(8), .NCH(3), .CNT_W(2), .SAT(1'b0)) u_bw (
    .clk(clk), .rst(b_rst), .s_tvalid(b_sv), .s_tready(bw_sr), .s_tdata(b_data),
    .s_tid(b_tid), .s_tlast(b_last), .m_tvalid(bw_mv), .m_tready(b_mr),
    .m_tdata(bw_md), .m_tid(bw_mid), .m_tcount(bw_mc), .m_tovf(bw_movf), .m_tlast(bw_mlast)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] msk(input longint v, input int w);
    return 64'(v) & ((64'd1 << w) - 64'd1);
  endfunction

  // Model of the default instance: frame sums as plain integers
  localparam longint A_MAX = (longint'(1) <<< 47) - 1;
  localparam longint A_MIN = -(longint'(1) <<< 47);
  longint a_acc [4];
  int     a_cnt [4];
  bit     a_ovf [4];
  bit     ae_v;
  longint ae_d;
  int     ae_id, ae_c;
  bit     ae_o;

  task automatic a_step(input bit v, input longint d, input int id, input bit last,
                        input bit mr, input bit rstv);
    longint s;
    bit o, acc;
    @(negedge clk);
    a_rst = rstv; a_sv = v; a_data = 32'(d); a_tid = 2'(id); a_last = last; a_mr = mr;
    #1;
    chk("a_s_tready", 64'(a_sr), 64'(rstv & (!ae_v | mr)));
    if (!rstv) begin
      for (int c = 0; c < 4; c++) begin a_acc[c] = 0; a_cnt[c] = 0; a_ovf[c] = 0; end
      ae_v = 0; ae_d = 0; ae_id = 0; ae_c = 0; ae_o = 0;
    end else begin
      acc = v & (!ae_v | mr);
      if (ae_v && mr) ae_v = 0;
      if (acc) begin
        s = a_acc[id] + d;
        o = (s > A_MAX) || (s < A_MIN);
        if (s > A_MAX) s = A_MAX;
        if (s < A_MIN) s = A_MIN;
        if (last) begin
          ae_v = 1; ae_d = s; ae_id = id; ae_o = a_ovf[id] | o;
          ae_c = (a_cnt[id] + 1 > 65535) ? 65535 : a_cnt[id] + 1;
          a_acc[id] = 0; a_cnt[id] = 0; a_ovf[id] = 0;
        end else begin
          a_acc[id] = s; a_ovf[id] = a_ovf[id] | o;
          a_cnt[id] = (a_cnt[id] + 1 > 65535) ? 65535 : a_cnt[id] + 1;
        end
      end
    end
    @(posedge clk); #1;
    chk("a_m_tvalid", 64'(a_mv), 64'(ae_v));
    if (ae_v || !rstv) begin
      chk("a_m_tdata", 64'(a_md), msk(ae_d, 48));
      chk("a_m_tid", 64'(a_mid), msk(ae_id, 2));
      chk("a_m_tcount", 64'(a_mc), msk(ae_c, 16));
      chk("a_m_tovf", 64'(a_movf), 64'(ae_o));
      chk("a_m_tlast", 64'(a_mlast), 64'(ae_v && ae_id == 3));
    end
    a_sv = 1'b0; a_mr = 1'b0; a_rst = 1'b1;
  endtask

  // Model of the small instances; index 0 saturates, index 1 wraps
  int b_acc [2][3];
  int b_cnt [2][3];
  bit b_ovf [2][3];
  bit be_v [2];
  int be_d [2], be_id [2], be_c [2];
  bit be_o [2];

  task automatic b_step(input bit v, input int d, input int id, input bit last,
                        input bit mr, input bit rstv);
    int s;
    bit o, acc;
    logic [7:0] md;
    logic [1:0] mid, mc;
    logic mv, movf, mlast, sr;
    @(negedge clk);
    b_rst = rstv; b_sv = v; b_data = 8'(d); b_tid = 2'(id); b_last = last; b_mr = mr;
    #1;
    for (int m = 0; m < 2; m++) begin
      sr = (m == 0) ? bs_sr : bw_sr;
      chk(m == 0 ? "bs_s_tready" : "bw_s_tready", 64'(sr), 64'(rstv & (!be_v[m] | mr)));
      if (!rstv) begin
        for (int c = 0; c < 3; c++) begin b_acc[m][c] = 0; b_cnt[m][c] = 0; b_ovf[m][c] = 0; end
        be_v[m] = 0; be_d[m] = 0; be_id[m] = 0; be_c[m] = 0; be_o[m] = 0;
      end else begin
        acc = v & (!be_v[m] | mr);
        if (be_v[m] && mr) be_v[m] = 0;
        if (acc && id < 3) begin
          s = b_acc[m][id] + d;
          o = (s > 127) || (s < -128);
          if (m == 0) begin
            if (s > 127) s = 127;
            if (s < -128) s = -128;
          end else begin
            if (s > 127) s = s - 256;
            if (s < -128) s = s + 256;
          end
          if (last) begin
            be_v[m] = 1; be_d[m] = s; be_id[m] = id; be_o[m] = b_ovf[m][id] | o;
            be_c[m] = (b_cnt[m][id] + 1 > 3) ? 3 : b_cnt[m][id] + 1;
            b_acc[m][id] = 0; b_cnt[m][id] = 0; b_ovf[m][id] = 0;
          end else begin
            b_acc[m][id] = s; b_ovf[m][id] = b_ovf[m][id] | o;
            b_cnt[m][id] = (b_cnt[m][id] + 1 > 3) ? 3 : b_cnt[m][id] + 1;
          end
        end
      end
    end
    @(posedge clk); #1;
    for (int m = 0; m < 2; m++) begin
      mv = (m == 0) ? bs_mv : bw_mv;       md = (m == 0) ? bs_md : bw_md;
      mid = (m == 0) ? bs_mid : bw_mid;    mc = (m == 0) ? bs_mc : bw_mc;
      movf = (m == 0) ? bs_movf : bw_movf; mlast = (m == 0) ? bs_mlast : bw_mlast;
      chk(m == 0 ? "bs_m_tvalid" : "bw_m_tvalid", 64'(mv), 64'(be_v[m]));
      if (be_v[m] || !rstv) begin
        chk(m == 0 ? "bs_m_tdata" : "bw_m_tdata", 64'(md), msk(be_d[m], 8));
        chk(m == 0 ? "bs_m_tid" : "bw_m_tid", 64'(mid), msk(be_id[m], 2));
        chk(m == 0 ? "bs_m_tcount" : "bw_m_tcount", 64'(mc), msk(be_c[m], 2));
        chk(m == 0 ? "bs_m_tovf" : "bw_m_tovf", 64'(movf), 64'(be_o[m]));
        chk(m == 0 ? "bs_m_tlast" : "bw_m_tlast", 64'(mlast), 64'(be_v[m] && be_id[m] == 2));
      end
    end
    b_sv = 1'b0; b_mr = 1'b0; b_rst = 1'b1;
  endtask

  initial begin
    // Reset both groups
    a_step(0, 0, 0, 0, 0, 0);
    b_step(0, 0, 0, 0, 0, 0);

    // Three-beat frame on ch0
    a_step(1, 3, 0, 0, 1, 1);
    a_step(1, 5, 0, 0, 1, 1);
    a_step(1, -2, 0, 1, 1, 1);
    chk("a_frame3_sum", 64'(a_md), 64'd6);
    chk("a_frame3_cnt", 64'(a_mc), 64'd3);
    a_step(0, 0, 0, 0, 1, 1);

    // Interleaved ch1/ch3 frames, back-to-back results with drain+reload
    a_step(1, 10, 1, 0, 1, 1);
    a_step(1, 7, 3, 1, 0, 1);
    chk("a_ch3_last", 64'(a_mlast), 64'd1);
    a_step(1, 20, 1, 1, 1, 1);
    chk("a_ch1_sum", 64'(a_md), 64'd30);
    a_step(1, 1, 3, 0, 1, 1);
    a_step(1, 0, 3, 1, 1, 1);
    chk("a_ch3_residual", 64'(a_md), 64'd1);
    a_step(0, 0, 0, 0, 1, 1);

    // Stalled output holds off input; then drain and reload in one cycle
    a_step(1, 9, 0, 1, 0, 1);
    for (int i = 0; i < 10; i++) a_step(1, longint'($signed($urandom())), 2, i[0], 0, 1);
    a_step(1, 11, 2, 1, 1, 1);
    chk("a_reload_sum", 64'(a_md), 64'd11);
    a_step(0, 0, 0, 0, 1, 1);

    // Reset mid-frame discards partial sum
    a_step(1, 50, 2, 0, 1, 1);
    a_step(1, 0, 0, 0, 1, 0);
    a_step(1, 4, 2, 1, 1, 1);
    chk("a_post_rst_cnt", 64'(a_mc), 64'd1);

    // Random traffic on the default instance
    for (int i = 0; i < 400; i++)
      a_step($urandom_range(0, 3) != 0, longint'($signed($urandom())),
             $urandom_range(0, 3), $urandom_range(0, 3) == 0,
             $urandom_range(0, 2) != 0, $urandom_range(0, 199) != 0);

    // Overflow: saturate to 127 vs wrap to -56
    b_step(1, 100, 0, 0, 1, 1);
    b_step(1, 100, 0, 1, 1, 1);
    chk("bs_ovf_sum", 64'(bs_md), 64'h7F);
    chk("bw_ovf_sum", 64'(bw_md), 64'hC8);
    chk("bw_ovf_flag", 64'(bw_movf), 64'd1);

    // Beat count saturates at 3
    for (int i = 0; i < 5; i++) b_step(1, 1, 1, i == 4, 1, 1);
    chk("bs_cnt_sat", 64'(bs_mc), 64'd3);
    chk("bs_cnt_sum", 64'(bs_md), 64'd5);

    // Out-of-range channel is swallowed
    b_step(1, 20, 0, 0, 1, 1);
    b_step(1, 99, 3, 1, 1, 1);
    b_step(1, 1, 0, 1, 1, 1);
    chk("bs_badch_sum", 64'(bs_md), 64'd21);

    // Random traffic on the small instances
    for (int i = 0; i < 400; i++)
      b_step($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)) - 128,
             $urandom_range(0, 3), $urandom_range(0, 5) == 0,
             $urandom_range(0, 2) != 0, $urandom_range(0, 199) != 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
